fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of the single-cycle RV32 datapath. It owns the program counter, issues word reads to instruction memory over a request/grant/response handshake, and buffers returned words in a small in-order queue. Each buffered word is presented to decode/execute as an `{inst, inst_pc}` pair with valid/ready. Branch and jump redirects flush in-flight fetches and restart fetching at the new PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `DEPTH`, default 4: queue entries and maximum in-flight reads. Must be a power of 2 and ≥2.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `imem_req`  out  1  read request valid.
- `imem_addr`  out  32  word address of the request; bits [1:0] are always 0.
- `imem_gnt`  in  1  request accepted this cycle; only meaningful while `imem_req`=1.
- `imem_rvalid`  in  1  read data valid; responses return in order, at least 1 cycle after grant.
- `imem_rdata`  in  32  instruction word.
- `redirect`  in  1  taken branch/jump; one-cycle pulse.
- `redirect_pc`  in  32  new fetch target; bits [1:0] are forced to 0 internally.
- `inst_valid`  out  1  queue head holds a valid instruction.
- `inst`  out  32  instruction at the queue head.
- `inst_pc`  out  32  PC of `inst`.
- `inst_ready`  in  1  consumer accepts the head this cycle.

## Operation
- State registers:
  - `fetch_pc`: next address to request.
  - `resp_pc`: PC tagged onto the next accepted response.
  - `outstanding`: granted reads not yet returned (0..DEPTH).
  - `discard`: stale responses still to drop (0..DEPTH).
  - Circular queue of DEPTH `{pc, data}` entries with read/write pointers and `count`.
- Issue rule: `imem_req` = reset released && !redirect && (outstanding + count < DEPTH). This is combinational from registered values only. `imem_addr` = `fetch_pc`.
- Request persistence: the unit holds `imem_req`/`imem_addr` until `imem_gnt`, except when a redirect withdraws the request. Memory must tolerate a request withdrawn without a grant.
- On grant: `fetch_pc` += 4 (modulo 2^32, wraps), `outstanding` += 1.
- On `imem_rvalid`: `outstanding` -= 1.
  - If `discard` > 0: drop the word and decrement `discard`.
  - Otherwise: push `{resp_pc, imem_rdata}` and set `resp_pc` += 4.
- Pop: `inst_valid` && `inst_ready` advances the read pointer. Push and pop may occur in the same cycle; `count` is then unchanged.
- Redirect has priority over every other update in its cycle:
  - `fetch_pc` and `resp_pc` load `redirect_pc` & ~3.
  - Queue flushes: count=0 and pointers reset.
  - `discard` loads `outstanding` − (1 if `imem_rvalid`, else 0). A response arriving in the redirect cycle is dropped.
  - A concurrent pop is void.
  - `imem_req`=0 in the redirect cycle.
- Overflow: credits guarantee the queue cannot overflow. An `imem_rvalid` with `outstanding`=0 is a protocol violation; flag it with an assertion.
- Decode contract: the consumer must not change `redirect` based on an instruction it has not accepted.

## Timing
- During reset (`reset`=0):
  - `fetch_pc`=`resp_pc`=RESET_PC; `outstanding`=`discard`=`count`=0.
  - `imem_req`=0, `imem_addr`=RESET_PC, `inst_valid`=0; `inst` and `inst_pc` are don't-care (implemented as 0).
- First cycle after reset release: `imem_req`=1 at RESET_PC.
- Reset mid-operation discards all in-flight state. Instruction memory shares the same reset, so no pre-reset response arrives afterwards.
- Latency: grant at cycle N → `imem_rvalid` at N+k (k≥1) → `inst_valid` at N+k+1 (queue write, no bypass).
- Throughput: with k=1, DEPTH=4 and `inst_ready`=1, one instruction per cycle in steady state.
- Redirect at cycle R:
  - `inst_valid`=0 at R+1.
  - New request at `redirect_pc` issues at R+1 if credits allow (`outstanding` still counts the stale reads).
  - First new instruction no earlier than R+3.
- Back-to-back redirects: the later one wins; `discard` is recomputed from the current `outstanding`.
- `inst`/`inst_pc` hold steady while `inst_valid`=1 and `inst_ready`=0.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with random memory inputs → `imem_req`=0 and `inst_valid`=0 throughout; first request after release is at 0x0000_0000.
- Streaming: 1-cycle memory returning `data = addr ^ 32'hA5A5_0000`, `inst_ready`=1 → `inst_pc` sequence 0x0, 0x4, 0x8, … with one instruction per cycle from cycle 3; `inst` matches the data function.
- Backpressure: `inst_ready`=0 for 10 cycles → exactly 4 grants, then `imem_req`=0. Raise `inst_ready` → PCs 0x0–0xC delivered in order with none lost; fetching resumes at 0x10.
- Redirect with 2 in flight: 3-cycle memory, `redirect`=1 with `redirect_pc`=0x103 → both stale responses dropped, next request at 0x100, first `inst_valid` has `inst_pc`=0x100.
- Simultaneous events: `redirect`, `imem_rvalid` and pop in the same cycle with `outstanding`=2 → that response dropped, `discard`=1, queue empty next cycle, only one further stale word dropped.
- Wrap and reset mid-stream: redirect to 0xFFFF_FFF8 → PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. Assert `reset`=0 with 2 outstanding → all state cleared; restart at RESET_PC with `discard`=0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: RV32 instruction fetch stage. Owns the PC, issues word reads
// over a req/gnt/rvalid handshake, and buffers in-order responses in a small
// credit-managed queue presented to decode as {inst, inst_pc} with valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [SW-1:0] DEPTH_W = SW'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [31:0]   r_q_pc   [DEPTH];
  logic [31:0]   r_q_data [DEPTH];

  logic [SW-1:0] w_credits_used;
  logic [31:0]   w_redirect_pc;
  logic          w_grant;
  logic          w_push;
  logic          w_pop;

  // Every in-flight read and every buffered word holds one queue slot, so the
  // queue can never overflow when a response lands.
  assign w_credits_used = {1'b0, r_outstanding} + {1'b0, r_count};
  assign w_redirect_pc  = redirect_pc & ~32'd3;

  assign imem_req  = reset && !redirect && (w_credits_used < DEPTH_W);
  assign imem_addr = r_fetch_pc;
  assign w_grant   = imem_req && imem_gnt;

  // A redirect voids both the arriving word and any pop in the same cycle.
  assign w_push = reset && imem_rvalid && (r_discard == '0) && !redirect;
  assign w_pop  = reset && inst_valid && inst_ready && !redirect;

  assign inst_valid = (r_count != '0);
  assign inst       = inst_valid ? r_q_data[r_rd_ptr] : '0;
  assign inst_pc    = inst_valid ? r_q_pc[r_rd_ptr]   : '0;

  // Control state: PCs, credit counters, queue pointers; redirect wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else if (redirect) begin
      r_fetch_pc <= w_redirect_pc;
      r_resp_pc  <= w_redirect_pc;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      // Stale reads still in flight after this cycle must be dropped on return.
      if (imem_rvalid) begin
        r_outstanding <= r_outstanding - CNT_ONE;
        r_discard     <= r_outstanding - CNT_ONE;
      end else begin
        r_discard     <= r_outstanding;
      end
    end else begin
      if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;

      unique case ({w_grant, imem_rvalid})
        2'b10:   r_outstanding <= r_outstanding + CNT_ONE;
        2'b01:   r_outstanding <= r_outstanding - CNT_ONE;
        default: r_outstanding <= r_outstanding;
      endcase

      if (imem_rvalid && (r_discard != '0)) r_discard <= r_discard - CNT_ONE;

      if (w_push) begin
        r_resp_pc <= r_resp_pc + 32'd4;
        r_wr_ptr  <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;

      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue payload write.
  // NOTE: payload storage is not reset; r_count alone defines which entries
  // are valid, and outputs are gated to 0 while the queue is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]   <= r_resp_pc;
      r_q_data[r_wr_ptr] <= imem_rdata;
    end
  end

  // A response with no read outstanding means the memory broke the protocol.
  a_rvalid_has_credit: assert property (
    @(posedge clk) disable iff (!reset) imem_rvalid |-> (r_outstanding != '0)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with an in-order memory model
// of configurable latency; each scenario task checks its own expectations.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int n_checks = 0;
  int n_errors = 0;

  // Memory model: granted addresses wait in order until their due cycle.
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       mq[$];
  int          lat = 1;
  bit          mem_rand = 1'b0;
  int          cyc = 0;
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];

  // Values sampled just before each rising edge.
  logic        s_req, s_grant, s_valid;
  logic [31:0] s_addr, s_pc, s_inst;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  always #5 clk = ~clk;

  // One clock cycle: drive memory, sample, clock, advance the memory model.
  task automatic tick();
    if (!reset) mq.delete();
    if (mem_rand) begin
      imem_gnt    = 1'($urandom_range(0, 1));
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
    end else begin
      imem_gnt = 1'b1;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mq[0].addr ^ KEY;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
      end
    end
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_grant = imem_req && imem_gnt;
    s_valid = inst_valid;
    s_pc    = inst_pc;
    s_inst  = inst;
    if (reset && !redirect && inst_valid && inst_ready) begin
      got_pc.push_back(inst_pc);
      got_inst.push_back(inst);
    end
    @(posedge clk);
    if (reset && !mem_rand) begin
      if (s_grant) mq.push_back('{addr: s_addr, due: cyc + lat});
      if (imem_rvalid && mq.size() > 0) void'(mq.pop_front());
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    redirect = 1'b0;
    mem_rand = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    got_pc.delete();
    got_inst.delete();
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    redirect   = 1'b0;
    mem_rand   = 1'b1;
    inst_ready = 1'($urandom_range(0, 1));
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (s_req !== 1'b0) begin
        n_errors++; $display("FAIL reset_req cyc %0d: got %b want 0", i, s_req);
      end
      n_checks++;
      if (s_valid !== 1'b0) begin
        n_errors++; $display("FAIL reset_valid cyc %0d: got %b want 0", i, s_valid);
      end
      n_checks++;
      if (s_addr !== RESET_PC) begin
        n_errors++; $display("FAIL reset_addr cyc %0d: got %h want %h", i, s_addr, RESET_PC);
      end
    end
    mem_rand   = 1'b0;
    reset      = 1'b1;
    inst_ready = 1'b1;
    tick();
    n_checks++;
    if ({s_req, s_addr} !== {1'b1, RESET_PC}) begin
      n_errors++; $display("FAIL reset_first_req: got req=%b addr=%h want req=1 addr=%h", s_req, s_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    logic [31:0] pc;
    lat = 1; inst_ready = 1'b1;
    do_reset();
    for (int t = 0; t < 12; t++) begin
      tick();
      n_checks++;
      if ({s_req, s_addr} !== {1'b1, 32'(4 * t)}) begin
        n_errors++; $display("FAIL stream_req t=%0d: got req=%b addr=%h want req=1 addr=%h", t, s_req, s_addr, 32'(4 * t));
      end
      n_checks++;
      if (s_valid !== (t >= 2)) begin
        n_errors++; $display("FAIL stream_valid t=%0d: got %b want %b", t, s_valid, (t >= 2));
      end
      if (t >= 2) begin
        pc = 32'(4 * (t - 2));
        n_checks++;
        if ({s_pc, s_inst} !== {pc, pc ^ KEY}) begin
          n_errors++; $display("FAIL stream_data t=%0d: got pc=%h inst=%h want pc=%h inst=%h", t, s_pc, s_inst, pc, pc ^ KEY);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int          grants;
    bit          seen;
    logic [31:0] first;
    lat = 1; inst_ready = 1'b0;
    do_reset();
    grants = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (s_grant) grants++;
      if (t >= 2) begin
        n_checks++;
        if ({s_valid, s_pc, s_inst} !== {1'b1, 32'h0, KEY}) begin
          n_errors++; $display("FAIL bp_hold t=%0d: got v=%b pc=%h inst=%h want v=1 pc=0 inst=%h", t, s_valid, s_pc, s_inst, KEY);
        end
      end
    end
    n_checks++;
    if (grants !== 4) begin
      n_errors++; $display("FAIL bp_grants: got %0d want 4", grants);
    end
    n_checks++;
    if (s_req !== 1'b0) begin
      n_errors++; $display("FAIL bp_req_stall: got %b want 0", s_req);
    end
    inst_ready = 1'b1;
    seen = 1'b0; first = '0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (s_grant && !seen) begin seen = 1'b1; first = s_addr; end
    end
    n_checks++;
    if ({seen, first} !== {1'b1, 32'h10}) begin
      n_errors++; $display("FAIL bp_resume: got seen=%b addr=%h want seen=1 addr=00000010", seen, first);
    end
    n_checks++;
    if (got_pc.size() < 5) begin
      n_errors++; $display("FAIL bp_count: got %0d pops want >=5", got_pc.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if ({got_pc[i], got_inst[i]} !== {32'(4 * i), 32'(4 * i) ^ KEY}) begin
          n_errors++; $display("FAIL bp_order i=%0d: got pc=%h inst=%h want pc=%h", i, got_pc[i], got_inst[i], 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_redirect();
    lat = 3; inst_ready = 1'b1;
    do_reset();
    for (int t = 0; t < 11; t++) begin
      redirect    = (t == 2);
      redirect_pc = 32'h0000_0103;
      tick();
      if (t == 2) begin
        n_checks++;
        if (s_req !== 1'b0) begin
          n_errors++; $display("FAIL redir_req_low: got %b want 0", s_req);
        end
      end
      if (t == 3) begin
        n_checks++;
        if ({s_grant, s_addr} !== {1'b1, 32'h100}) begin
          n_errors++; $display("FAIL redir_new_req: got gnt=%b addr=%h want gnt=1 addr=00000100", s_grant, s_addr);
        end
      end
      if (t >= 3 && t <= 6) begin
        n_checks++;
        if (s_valid !== 1'b0) begin
          n_errors++; $display("FAIL redir_valid_low t=%0d: got %b want 0", t, s_valid);
        end
      end
      if (t == 7) begin
        n_checks++;
        if ({s_valid, s_pc, s_inst} !== {1'b1, 32'h100, 32'h100 ^ KEY}) begin
          n_errors++; $display("FAIL redir_first: got v=%b pc=%h inst=%h want v=1 pc=00000100", s_valid, s_pc, s_inst);
        end
      end
    end
    redirect = 1'b0;
    n_checks++;
    if (got_pc.size() < 2 || got_pc[0] !== 32'h100 || got_pc[1] !== 32'h104) begin
      n_errors++; $display("FAIL redir_seq: got %0d pops first=%h want 00000100,00000104", got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'hX);
    end
  endtask

  task automatic test_simultaneous();
    lat = 2; inst_ready = 1'b1;
    do_reset();
    for (int t = 0; t < 10; t++) begin
      redirect    = (t == 3);
      redirect_pc = 32'h0000_0200;
      tick();
      if (t == 3) begin
        n_checks++;
        if ({s_valid, s_pc, imem_rvalid, s_req} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
          n_errors++; $display("FAIL simul_setup: got v=%b pc=%h rvalid=%b req=%b want 1,0,1,0", s_valid, s_pc, imem_rvalid, s_req);
        end
      end
      if (t == 4) begin
        n_checks++;
        if ({s_grant, s_addr} !== {1'b1, 32'h200}) begin
          n_errors++; $display("FAIL simul_new_req: got gnt=%b addr=%h want gnt=1 addr=00000200", s_grant, s_addr);
        end
      end
      if (t >= 4 && t <= 6) begin
        n_checks++;
        if (s_valid !== 1'b0) begin
          n_errors++; $display("FAIL simul_empty t=%0d: got %b want 0", t, s_valid);
        end
      end
      if (t == 7) begin
        n_checks++;
        if ({s_valid, s_pc, s_inst} !== {1'b1, 32'h200, 32'h200 ^ KEY}) begin
          n_errors++; $display("FAIL simul_first: got v=%b pc=%h inst=%h want v=1 pc=00000200 inst=%h", s_valid, s_pc, s_inst, 32'h200 ^ KEY);
        end
      end
    end
    redirect = 1'b0;
    n_checks++;
    if (got_pc.size() < 2 || got_pc[0] !== 32'h200 || got_pc[1] !== 32'h204) begin
      n_errors++; $display("FAIL simul_seq: got %0d pops first=%h want 00000200,00000204", got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'hX);
    end
  endtask

  task automatic test_wrap_reset();
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'hFFFF_FFF8;
    exp_addr[1] = 32'hFFFF_FFFC;
    exp_addr[2] = 32'h0000_0000;
    lat = 1; inst_ready = 1'b1;
    do_reset();
    for (int t = 0; t < 7; t++) begin
      redirect    = (t == 0);
      redirect_pc = 32'hFFFF_FFF8;
      tick();
      if (t >= 1 && t <= 3) begin
        n_checks++;
        if ({s_grant, s_addr} !== {1'b1, exp_addr[t - 1]}) begin
          n_errors++; $display("FAIL wrap_req t=%0d: got gnt=%b addr=%h want gnt=1 addr=%h", t, s_grant, s_addr, exp_addr[t - 1]);
        end
      end
    end
    redirect = 1'b0;
    n_checks++;
    if (got_pc.size() < 3) begin
      n_errors++; $display("FAIL wrap_count: got %0d pops want >=3", got_pc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if ({got_pc[i], got_inst[i]} !== {exp_addr[i], exp_addr[i] ^ KEY}) begin
          n_errors++; $display("FAIL wrap_pc i=%0d: got pc=%h inst=%h want pc=%h", i, got_pc[i], got_inst[i], exp_addr[i]);
        end
      end
    end

    // Reset while two reads are in flight.
    lat = 3;
    do_reset();
    repeat (2) tick();
    reset = 1'b0;
    for (int t = 0; t < 2; t++) begin
      tick();
      n_checks++;
      if ({s_req, s_valid} !== 2'b00) begin
        n_errors++; $display("FAIL midreset_idle t=%0d: got req=%b valid=%b want 0,0", t, s_req, s_valid);
      end
    end
    reset = 1'b1;
    got_pc.delete();
    got_inst.delete();
    for (int t = 0; t < 6; t++) begin
      tick();
      if (t <= 2) begin
        n_checks++;
        if ({s_grant, s_addr} !== {1'b1, RESET_PC + 32'(4 * t)}) begin
          n_errors++; $display("FAIL midreset_req t=%0d: got gnt=%b addr=%h want gnt=1 addr=%h", t, s_grant, s_addr, RESET_PC + 32'(4 * t));
        end
      end
      if (t == 4) begin
        n_checks++;
        if ({s_valid, s_pc, s_inst} !== {1'b1, RESET_PC, RESET_PC ^ KEY}) begin
          n_errors++; $display("FAIL midreset_first: got v=%b pc=%h inst=%h want v=1 pc=%h", s_valid, s_pc, s_inst, RESET_PC);
        end
      end
    end
  endtask

  initial begin
    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    inst_ready  = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_simultaneous();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
